// File: rtl/afilter_pkg.sv
// Shared adaptive-filter package: default geometry, sample type and a width helper
// used by the tap memory, MAC and LMS blocks.
package afilter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_DEPTH = 8;

  // Sample width shared by every datapath block of the filter.
  localparam int unsigned SAMPLE_W = DEFAULT_WIDTH;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Width needed to count 0..depth inclusive.
  function automatic int unsigned fill_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tap_memory_if.sv
// Bus interface of tap_memory: sample write, tap read and fill status.
// The clear signal exists only when TAP_MEMORY_CLEAR_EN is defined.
interface tap_memory_if #(
  parameter int unsigned WIDTH = afilter_pkg::DEFAULT_WIDTH,
  parameter int unsigned DEPTH = afilter_pkg::DEFAULT_DEPTH
) ();
  import afilter_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = fill_width(DEPTH);

  logic             enable;
  logic [WIDTH-1:0] d;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_oldest;
  logic [CW-1:0]    fill_count;
  logic             full;
  logic             done;
`ifdef TAP_MEMORY_CLEAR_EN
  logic             clear;
`endif

  modport master (
    output enable,
    output d,
    output rd_addr,
`ifdef TAP_MEMORY_CLEAR_EN
    output clear,
`endif
    input  q,
    input  q_oldest,
    input  fill_count,
    input  full,
    input  done
  );

  modport slave (
    input  enable,
    input  d,
    input  rd_addr,
`ifdef TAP_MEMORY_CLEAR_EN
    input  clear,
`endif
    output q,
    output q_oldest,
    output fill_count,
    output full,
    output done
  );

endinterface

// File: rtl/tap_register.sv
// One WIDTH-bit delay-line stage with load enable.
// Optional synchronous clear when TAP_MEMORY_CLEAR_EN is defined.
module tap_register #(
  parameter int unsigned WIDTH = afilter_pkg::DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
`ifdef TAP_MEMORY_CLEAR_EN
  input  logic             clear,
`endif
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Stage storage: clear beats enable so a dropped sample never lands.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
`ifdef TAP_MEMORY_CLEAR_EN
    end else if (clear) begin
      q <= '0;
`endif
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/tap_memory.sv
// DEPTH-stage, WIDTH-bit tap delay line with registered random-access read,
// oldest-tap view, fill counter and write acknowledge.
// Optional feature macro: TAP_MEMORY_CLEAR_EN (adds a synchronous clear).
module tap_memory
  import afilter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic         clock,
  input  logic         reset,
  tap_memory_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = fill_width(DEPTH);

  logic [WIDTH-1:0] taps    [DEPTH];
  logic [WIDTH-1:0] tap_in  [DEPTH];
  logic             clr;

  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] q_q;
  logic [CW-1:0]    fill_q, fill_d;
  logic             full_q;
  logic             done_q;

`ifdef TAP_MEMORY_CLEAR_EN
  assign clr = bus.clear;
`else
  assign clr = 1'b0;
`endif

  // Shift chain: tap 0 takes the new sample, each later tap takes its predecessor.
  for (genvar g = 0; g < DEPTH; g++) begin : g_tap
    if (g == 0) begin : g_head
      assign tap_in[g] = bus.d;
    end else begin : g_body
      assign tap_in[g] = taps[g-1];
    end

    tap_register #(
      .WIDTH (WIDTH)
    ) u_tap (
      .clock  (clock),
      .reset  (reset),
      .enable (bus.enable),
`ifdef TAP_MEMORY_CLEAR_EN
      .clear  (clr),
`endif
      .d      (tap_in[g]),
      .q      (taps[g])
    );
  end

  // Read mux over pre-edge taps; addresses beyond DEPTH-1 return zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.rd_addr == AW'(i)) begin
        rd_data = taps[i];
      end
    end
  end

  // Saturating fill count for the next edge.
  always_comb begin
    fill_d = fill_q;
    if (clr) begin
      fill_d = '0;
    end else if (bus.enable && (fill_q != CW'(DEPTH))) begin
      fill_d = fill_q + CW'(1);
    end
  end

  // Registered read data, fill status and write acknowledge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      fill_q <= '0;
      full_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      q_q    <= clr ? '0 : rd_data;
      fill_q <= fill_d;
      full_q <= (fill_d == CW'(DEPTH));
      done_q <= bus.enable && !clr;
    end
  end

  assign bus.q          = q_q;
  assign bus.q_oldest   = taps[DEPTH-1];
  assign bus.fill_count = fill_q;
  assign bus.full       = full_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_tap_memory.sv
// Directed bench for tap_memory: DEPTH=8 and DEPTH=5 instances sharing clock/reset.
// The clear scenario is exercised when TAP_MEMORY_CLEAR_EN is defined.
module tb_tap_memory;

  logic clock = 1'b0;
  logic reset;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  tap_memory_if #(.WIDTH(16), .DEPTH(8)) bus8 ();
  tap_memory_if #(.WIDTH(16), .DEPTH(5)) bus5 ();

  tap_memory #(.WIDTH(16), .DEPTH(8)) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (bus8)
  );

  tap_memory #(.WIDTH(16), .DEPTH(5)) dut5 (
    .clock (clock),
    .reset (reset),
    .bus   (bus5)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus8.enable = 1'b1; bus8.d = 16'h7FFF; bus8.rd_addr = '0;
    bus5.enable = 1'b1; bus5.d = 16'h7FFF; bus5.rd_addr = '0;
`ifdef TAP_MEMORY_CLEAR_EN
    bus8.clear = 1'b0;
    bus5.clear = 1'b0;
`endif
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if (bus8.q !== 16'h0) begin
        fails++; $display("FAIL reset_q cyc %0d: got %h want 0000", c, bus8.q);
      end
      tests++;
      if (bus8.q_oldest !== 16'h0) begin
        fails++; $display("FAIL reset_q_oldest cyc %0d: got %h want 0000", c, bus8.q_oldest);
      end
      tests++;
      if (bus8.fill_count !== 4'd0) begin
        fails++; $display("FAIL reset_fill cyc %0d: got %0d want 0", c, bus8.fill_count);
      end
      tests++;
      if (bus8.full !== 1'b0 || bus8.done !== 1'b0) begin
        fails++;
        $display("FAIL reset_flags cyc %0d: got full=%b done=%b want 0 0", c, bus8.full,
                 bus8.done);
      end
      tests++;
      if (bus5.q !== 16'h0 || bus5.done !== 1'b0) begin
        fails++; $display("FAIL reset_d5 cyc %0d: got q=%h done=%b want 0 0", c, bus5.q,
                          bus5.done);
      end
    end
    bus8.enable = 1'b0;
    bus5.enable = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_fill();
    bus8.rd_addr = '0;
    for (int k = 1; k <= 8; k++) begin
      bus8.d = 16'(k);
      bus8.enable = 1'b1;
      step();
      tests++;
      if (bus8.done !== 1'b1) begin
        fails++; $display("FAIL fill_done k=%0d: got %b want 1", k, bus8.done);
      end
      tests++;
      if (32'(bus8.fill_count) !== 32'(k)) begin
        fails++; $display("FAIL fill_count k=%0d: got %0d want %0d", k, bus8.fill_count, k);
      end
      tests++;
      if (bus8.full !== (k == 8)) begin
        fails++; $display("FAIL fill_full k=%0d: got %b want %b", k, bus8.full, k == 8);
      end
    end
    tests++;
    if (bus8.q_oldest !== 16'd1) begin
      fails++; $display("FAIL fill_q_oldest: got %h want 0001", bus8.q_oldest);
    end
    bus8.enable = 1'b0;
    step();
    tests++;
    if (bus8.done !== 1'b0 || bus8.full !== 1'b1) begin
      fails++; $display("FAIL fill_idle: got done=%b full=%b want 0 1", bus8.done, bus8.full);
    end
    for (int i = 0; i < 8; i++) begin
      bus8.rd_addr = 3'(i);
      step();
      tests++;
      if (bus8.q !== 16'(8 - i)) begin
        fails++; $display("FAIL fill_read addr=%0d: got %h want %h", i, bus8.q, 16'(8 - i));
      end
    end
  endtask

  task automatic test_overflow();
    bus8.d = 16'd9;
    bus8.enable = 1'b1;
    step();
    tests++;
    if (bus8.fill_count !== 4'd8 || bus8.full !== 1'b1 || bus8.done !== 1'b1) begin
      fails++;
      $display("FAIL overflow_status: got fill=%0d full=%b done=%b want 8 1 1",
               bus8.fill_count, bus8.full, bus8.done);
    end
    tests++;
    if (bus8.q_oldest !== 16'd2) begin
      fails++; $display("FAIL overflow_q_oldest: got %h want 0002", bus8.q_oldest);
    end
    bus8.enable = 1'b0;
    bus8.rd_addr = 3'd0;
    step();
    tests++;
    if (bus8.q !== 16'd9) begin
      fails++; $display("FAIL overflow_tap0: got %h want 0009", bus8.q);
    end
  endtask

  task automatic test_read_before_write();
    bus8.rd_addr = 3'd0;
    bus8.d = 16'hA5A5;
    bus8.enable = 1'b1;
    step();
    tests++;
    if (bus8.q !== 16'd9) begin
      fails++; $display("FAIL rbw_pre: got %h want 0009", bus8.q);
    end
    bus8.enable = 1'b0;
    step();
    tests++;
    if (bus8.q !== 16'hA5A5) begin
      fails++; $display("FAIL rbw_post: got %h want a5a5", bus8.q);
    end
  endtask

  task automatic test_gaps();
    bus5.rd_addr = 3'd0;
    for (int k = 1; k <= 5; k++) begin
      bus5.d = 16'(k * 17);
      bus5.enable = 1'b1;
      step();
      tests++;
      if (bus5.done !== 1'b1 || 32'(bus5.fill_count) !== 32'(k)) begin
        fails++;
        $display("FAIL gaps_write k=%0d: got done=%b fill=%0d want 1 %0d", k, bus5.done,
                 bus5.fill_count, k);
      end
      tests++;
      if (bus5.full !== (k == 5)) begin
        fails++; $display("FAIL gaps_full k=%0d: got %b want %b", k, bus5.full, k == 5);
      end
      bus5.enable = 1'b0;
      step();
      tests++;
      if (bus5.done !== 1'b0 || 32'(bus5.fill_count) !== 32'(k)) begin
        fails++;
        $display("FAIL gaps_idle k=%0d: got done=%b fill=%0d want 0 %0d", k, bus5.done,
                 bus5.fill_count, k);
      end
      tests++;
      if (bus5.q !== 16'(k * 17)) begin
        fails++; $display("FAIL gaps_hold k=%0d: got %h want %h", k, bus5.q, 16'(k * 17));
      end
    end
    tests++;
    if (bus5.q_oldest !== 16'd17) begin
      fails++; $display("FAIL gaps_q_oldest: got %h want 0011", bus5.q_oldest);
    end
    bus5.rd_addr = 3'd6;
    step();
    tests++;
    if (bus5.q !== 16'h0) begin
      fails++; $display("FAIL gaps_oob: got %h want 0000", bus5.q);
    end
    bus5.rd_addr = 3'd4;
    step();
    tests++;
    if (bus5.q !== 16'd17) begin
      fails++; $display("FAIL gaps_last: got %h want 0011", bus5.q);
    end
  endtask

`ifdef TAP_MEMORY_CLEAR_EN
  task automatic test_clear();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    bus8.rd_addr = 3'd0;
    for (int k = 3; k <= 5; k++) begin
      bus8.d = 16'(k);
      bus8.enable = 1'b1;
      step();
    end
    bus8.d = 16'hBEEF;
    bus8.clear = 1'b1;
    step();
    tests++;
    if (bus8.done !== 1'b0 || bus8.fill_count !== 4'd0 || bus8.full !== 1'b0) begin
      fails++;
      $display("FAIL clear_status: got done=%b fill=%0d full=%b want 0 0 0", bus8.done,
               bus8.fill_count, bus8.full);
    end
    tests++;
    if (bus8.q !== 16'h0 || bus8.q_oldest !== 16'h0) begin
      fails++; $display("FAIL clear_data: got q=%h q_oldest=%h want 0 0", bus8.q,
                        bus8.q_oldest);
    end
    bus8.clear = 1'b0;
    bus8.enable = 1'b0;
    step();
    tests++;
    if (bus8.q !== 16'h0) begin
      fails++; $display("FAIL clear_dropped: got %h want 0000", bus8.q);
    end
  endtask
`endif

  task automatic test_reset_mid();
    bus8.rd_addr = 3'd0;
    bus8.d = 16'h1234;
    bus8.enable = 1'b1;
    step();
    tests++;
    if (bus8.done !== 1'b1) begin
      fails++; $display("FAIL midrst_pre_done: got %b want 1", bus8.done);
    end
    bus8.enable = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (bus8.q !== 16'h0 || bus8.q_oldest !== 16'h0) begin
      fails++; $display("FAIL midrst_data: got q=%h q_oldest=%h want 0 0", bus8.q,
                        bus8.q_oldest);
    end
    tests++;
    if (bus8.fill_count !== 4'd0 || bus8.full !== 1'b0 || bus8.done !== 1'b0) begin
      fails++;
      $display("FAIL midrst_status: got fill=%0d full=%b done=%b want 0 0 0",
               bus8.fill_count, bus8.full, bus8.done);
    end
    tests++;
    if (bus5.fill_count !== 3'd0 || bus5.q_oldest !== 16'h0) begin
      fails++; $display("FAIL midrst_d5: got fill=%0d q_oldest=%h want 0 0",
                        bus5.fill_count, bus5.q_oldest);
    end
    #1;
    reset = 1'b1;
    step();
    tests++;
    if (bus8.fill_count !== 4'd0 || bus8.q !== 16'h0) begin
      fails++; $display("FAIL midrst_after: got fill=%0d q=%h want 0 0", bus8.fill_count,
                        bus8.q);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_read_before_write();
    test_gaps();
`ifdef TAP_MEMORY_CLEAR_EN
    test_clear();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tap_memory.md
# tap_memory

Parametrised sample memory for the adaptive filter: a DEPTH-stage, WIDTH-bit shift memory that generalises the single-bit enable/done storage cell to a full tap delay line. Each accepted sample shifts in at tap 0, the oldest sample leaves at tap DEPTH-1, and any tap can be read through a registered random-access port. The block feeds the filter's tap-weight multiply/accumulate and LMS update stages, and reports fill status so the filter only adapts once the delay line holds DEPTH valid samples.

## Interface
- WIDTH, 16: sample width in bits, two's complement; minimum 1.
- DEPTH, 8: number of taps; minimum 2.
- AW, $clog2(DEPTH): read-address width; derived, not overridden.
- clock  in  1  rising-edge clock for all state.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  shift a new sample in this cycle.
- d  in  WIDTH  sample to write at tap 0.
- rd_addr  in  AW  tap index to read; 0 = newest.
- q  out  WIDTH  registered value of tap[rd_addr].
- q_oldest  out  WIDTH  combinational view of tap[DEPTH-1], for running-sum subtraction.
- fill_count  out  $clog2(DEPTH+1)  valid taps held; saturates at DEPTH.
- full  out  1  high when fill_count == DEPTH.
- done  out  1  one-cycle write acknowledge.
- clear  in  1  synchronous clear; present only with TAP_MEMORY_CLEAR_EN.

## Operation
- Reset (reset low, asynchronous): all taps = 0, q = 0, fill_count = 0, full = 0, done = 0. Release is synchronous to clock; the first accepted enable is the first rising edge with reset high.
- Shift: on a rising edge with enable = 1: tap[0] <= d, tap[i] <= tap[i-1] for i = 1..DEPTH-1; the old tap[DEPTH-1] is discarded.
- Fill: fill_count increments on each accepted enable until it reaches DEPTH, then holds; full = (fill_count == DEPTH), registered.
- done: registered; 1 for exactly the cycle after each accepted enable, else 0. Back-to-back enables give done high continuously.
- Read: every rising edge, q <= tap[rd_addr] using the pre-edge contents (read-before-write). When rd_addr >= DEPTH (non-power-of-2 DEPTH), q <= 0.
- q_oldest: always equals the current tap[DEPTH-1]; no latency.
- Taps not yet filled read as 0, never X.
- enable = 0: taps, fill_count and full hold; q still tracks rd_addr.

## Timing
- Write latency: sample on d at edge N is visible at tap 0 after edge N; q shows it after edge N+1 when rd_addr = 0.
- Read latency: 1 cycle from rd_addr to q.
- Simultaneous enable and read at edge N: q gets the pre-shift value.
- full rises in the cycle after the DEPTH-th accepted enable, together with done.
- Reset mid-operation: every output returns to its reset value immediately and asynchronously; samples in flight are lost.

## Configuration
- TAP_MEMORY_CLEAR_EN defined: clear port exists. Clear high at a rising edge zeros all taps, q, fill_count, full and done, and takes priority over a same-cycle enable; that sample is dropped and done stays 0.
- TAP_MEMORY_CLEAR_EN undefined: no clear port; state is cleared only by reset.

## Structure
- Shared package afilter_pkg: DEFAULT_WIDTH = 16, DEFAULT_DEPTH = 8, and the sample type/width constant shared with the MAC and LMS blocks.
- Sub-module tap_register: one WIDTH-bit stage with clock, reset, enable and optional clear. tap_memory instantiates DEPTH of them in a generate loop; the fill, done and read logic stays in the top level.

## Test plan
- Reset: hold reset low 3 cycles with enable = 1 and d = 16'h7FFF -> q = 0, q_oldest = 0, fill_count = 0, full = 0, done = 0 throughout.
- Fill: WIDTH = 16, DEPTH = 8; write 1..8 on consecutive cycles -> done high for 8 cycles; full rises with the 8th done; q_oldest = 1; reading rd_addr 0..7 returns 8,7,...,1.
- Overflow: write 9 after full -> q_oldest = 2, fill_count stays 8, tap 0 reads 9.
- Read-before-write: rd_addr = 0 and enable with d = 16'hA5A5 in the same cycle -> q shows the previous tap 0 next cycle and 16'hA5A5 one cycle later.
- Gaps and out-of-range: DEPTH = 5; enable on alternate cycles -> done pulses singly, taps hold between writes; rd_addr = 6 -> q = 0.
- Clear / reset mid-fill: after 3 writes, assert clear together with enable (macro defined) -> all zero, done = 0, fill_count = 0; separately, pulse reset low mid-cycle -> outputs zero before the next edge.
